// File: rtl/hps_uio_bridge_mc.sv
// Multi-channel HPS UIO command decoder: IDE register/data channels with
// auto-incrementing addresses, plus a keyboard/mouse event FIFO.
module hps_uio_bridge_mc #(
    parameter int unsigned IDE_CH    = 2,
    parameter int unsigned EVT_DEPTH = 8,
    parameter int unsigned EVT_AW    = 3
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   io_strobe,
    input  logic                   io_fpga,
    input  logic                   io_uio,
    input  logic [15:0]            io_din,
    output logic [15:0]            io_dout,
    input  logic [15:0]            fpga_dout,
    output logic                   evt_valid,
    output logic [1:0]             evt_type,
    output logic [7:0]             evt_data,
    input  logic                   evt_ready,
    output logic                   evt_overflow,
    output logic [2:0]             mouse_buttons,
    input  logic [16*IDE_CH-1:0]   ide_din,
    output logic [15:0]            ide_dout,
    output logic [4:0]             ide_addr,
    output logic [1:0]             ide_sel,
    output logic                   ide_rd,
    output logic                   ide_wr,
    input  logic [6*IDE_CH-1:0]    ide_req
);

    localparam int unsigned CNT_W = EVT_AW + 1;

    localparam logic [15:0] CMD_BUTTONS = 16'h0002;
    localparam logic [15:0] CMD_MOUSE_X = 16'h0003;
    localparam logic [15:0] CMD_MOUSE_Y = 16'h0004;
    localparam logic [15:0] CMD_KEYB    = 16'h0005;
    localparam logic [15:0] CMD_DMA_WR  = 16'h0061;
    localparam logic [15:0] CMD_DMA_RD  = 16'h0062;
    localparam logic [15:0] CMD_STATUS  = 16'h0063;
    localparam logic [15:0] CMD_EVT_CLR = 16'h0064;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] data;
    } evt_t;

    logic [4:0]  wc;
    logic [15:0] cmd;
    logic        cs;
    logic [15:0] resp;

    logic        strobe_go;
    logic [15:0] cmd_cur;
    logic [15:0] ide_din_sel;
    logic [15:0] status_word;
    logic        evt_push;
    logic        evt_flush;
    logic [1:0]  evt_type_in;

    evt_t             evt_mem [EVT_DEPTH];
    logic [EVT_AW-1:0] wr_ptr;
    logic [EVT_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]  evt_cnt;
    logic              evt_full;
    logic              evt_pop;
    logic              push_ok;

    assign io_dout   = io_fpga ? fpga_dout : resp;
    assign strobe_go = io_uio & io_strobe;
    // At wc==0 the command is still on the bus, not yet in cmd.
    assign cmd_cur   = (wc == 5'd0) ? io_din : cmd;

    always_comb begin
        ide_din_sel = '0;
        for (int n = 0; n < int'(IDE_CH); n++) begin
            if (ide_sel == 2'(n)) ide_din_sel = ide_din[16*n +: 16];
        end
    end

    // Per-channel status word; zero once wc runs past the last channel.
    always_comb begin
        status_word = '0;
        for (int n = 0; n < int'(IDE_CH); n++) begin
            if (wc == 5'(n)) status_word = {4'hE, 2'(n), 4'b0000, ide_req[6*n +: 6]};
        end
    end

    always_comb begin
        evt_type_in = 2'd2;
        if (cmd == CMD_MOUSE_X) evt_type_in = 2'd0;
        else if (cmd == CMD_MOUSE_Y) evt_type_in = 2'd1;
    end

    assign evt_push  = strobe_go && (wc == 5'd1) &&
                       ((cmd == CMD_MOUSE_X) || (cmd == CMD_MOUSE_Y) || (cmd == CMD_KEYB));
    assign evt_flush = strobe_go && (wc == 5'd0) && (io_din == CMD_EVT_CLR);

    // Frame decoder, IDE strobes and address auto-increment.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wc            <= '0;
            cmd           <= '0;
            cs            <= 1'b0;
            resp          <= '0;
            mouse_buttons <= '0;
            ide_dout      <= '0;
            ide_addr      <= '0;
            ide_sel       <= '0;
            ide_rd        <= 1'b0;
            ide_wr        <= 1'b0;
        end else begin
            ide_rd <= 1'b0;
            ide_wr <= 1'b0;
            // Register 0xF is the data port and must not advance.
            if ((ide_rd || ide_wr) && (ide_addr[3:0] != 4'hF)) ide_addr <= ide_addr + 5'd1;

            if (!io_uio) begin
                wc   <= '0;
                cs   <= 1'b0;
                resp <= '0;
            end else if (io_strobe) begin
                if (wc != 5'd31) wc <= wc + 5'd1;
                ide_dout <= io_din;
                resp     <= '0;
                if (wc == 5'd0) cmd <= io_din;
                if (cmd_cur == CMD_STATUS) resp <= status_word;

                if (wc == 5'd1) begin
                    case (cmd)
                        CMD_BUTTONS: mouse_buttons <= io_din[2:0];
                        CMD_DMA_WR, CMD_DMA_RD: begin
                            ide_addr <= {io_din[8], io_din[3:0]};
                            ide_sel  <= io_din[5:4];
                            cs       <= (io_din[15:9] == 7'b1111000) &&
                                        (32'(io_din[5:4]) < IDE_CH);
                        end
                        default: ;
                    endcase
                end

                if ((wc >= 5'd3) && cs) begin
                    if (cmd == CMD_DMA_WR) begin
                        ide_wr <= 1'b1;
                    end else if (cmd == CMD_DMA_RD) begin
                        resp   <= ide_din_sel;
                        ide_rd <= 1'b1;
                    end
                end
            end
        end
    end

    assign evt_full  = (evt_cnt == CNT_W'(EVT_DEPTH));
    assign evt_pop   = evt_valid & evt_ready;
    assign push_ok   = evt_push & (~evt_full | evt_pop);
    assign evt_valid = (evt_cnt != '0);
    assign evt_type  = evt_mem[rd_ptr].typ;
    assign evt_data  = evt_mem[rd_ptr].data;

    // Event FIFO; flush wins over any simultaneous pop.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_cnt      <= '0;
            evt_overflow <= 1'b0;
            for (int i = 0; i < int'(EVT_DEPTH); i++) evt_mem[i] <= '0;
        end else if (evt_flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_cnt      <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                evt_mem[wr_ptr] <= '{typ: evt_type_in, data: io_din[7:0]};
                wr_ptr          <= wr_ptr + EVT_AW'(1);
            end
            if (evt_pop) rd_ptr <= rd_ptr + EVT_AW'(1);
            case ({push_ok, evt_pop})
                2'b10:   evt_cnt <= evt_cnt + CNT_W'(1);
                2'b01:   evt_cnt <= evt_cnt - CNT_W'(1);
                default: ;
            endcase
            if (evt_push && evt_full && !evt_pop) evt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hps_uio_bridge_mc.sv
// Directed bench for hps_uio_bridge_mc: table of IDE/status frame steps plus
// hand-written reset, event FIFO overflow, flush and full push+pop sequences.
module tb_hps_uio_bridge_mc;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        io_strobe, io_fpga, io_uio;
    logic [15:0] io_din, io_dout, fpga_dout;
    logic        evt_valid, evt_ready, evt_overflow;
    logic [1:0]  evt_type;
    logic [7:0]  evt_data;
    logic [2:0]  mouse_buttons;
    logic [31:0] ide_din;
    logic [15:0] ide_dout;
    logic [4:0]  ide_addr;
    logic [1:0]  ide_sel;
    logic        ide_rd, ide_wr;
    logic [11:0] ide_req;

    int checks = 0;
    int errors = 0;

    hps_uio_bridge_mc #(.IDE_CH(2), .EVT_DEPTH(8), .EVT_AW(3)) dut (
        .clk_sys(clk_sys), .reset(reset), .io_strobe(io_strobe), .io_fpga(io_fpga),
        .io_uio(io_uio), .io_din(io_din), .io_dout(io_dout), .fpga_dout(fpga_dout),
        .evt_valid(evt_valid), .evt_type(evt_type), .evt_data(evt_data),
        .evt_ready(evt_ready), .evt_overflow(evt_overflow), .mouse_buttons(mouse_buttons),
        .ide_din(ide_din), .ide_dout(ide_dout), .ide_addr(ide_addr), .ide_sel(ide_sel),
        .ide_rd(ide_rd), .ide_wr(ide_wr), .ide_req(ide_req)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        nf;    // start a new frame before this word
        logic [15:0] din;
        logic [15:0] rd;    // io_dout seen just before this strobe
        logic        wr;    // ide_wr after this strobe
        logic        rdp;   // ide_rd after this strobe
        logic [4:0]  addr;
        logic [1:0]  sel;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic nf, input logic [15:0] din, input logic [15:0] rd,
                       input logic wr, input logic rdp, input logic [4:0] addr,
                       input logic [1:0] sel);
        vec_t v;
        v.nf = nf; v.din = din; v.rd = rd; v.wr = wr; v.rdp = rdp; v.addr = addr; v.sel = sel;
        tv.push_back(v);
    endtask

    // Called at a negedge; leaves at the following negedge with strobe low.
    task automatic word(input logic [15:0] w, input logic rdy);
        io_din    = w;
        io_strobe = 1'b1;
        evt_ready = rdy;
        @(negedge clk_sys);
        io_strobe = 1'b0;
        evt_ready = 1'b0;
    endtask

    task automatic frame_start;
        @(negedge clk_sys);
        io_uio = 1'b0;
        @(negedge clk_sys);
        io_uio = 1'b1;
    endtask

    task automatic evt_frame(input logic [15:0] c, input logic [7:0] d, input logic rdy);
        frame_start();
        word(c, 1'b0);
        word({8'h00, d}, rdy);
    endtask

    task automatic pop_check(input string nm, input logic [1:0] t, input logic [7:0] d);
        chk({nm, "_valid"}, 32'(evt_valid), 32'd1);
        chk({nm, "_type"}, 32'(evt_type), 32'(t));
        chk({nm, "_data"}, 32'(evt_data), 32'(d));
        evt_ready = 1'b1;
        @(negedge clk_sys);
        evt_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; io_strobe = 1'b0; io_fpga = 1'b0; io_uio = 1'b0; io_din = '0;
        fpga_dout = 16'hBEEF; evt_ready = 1'b0;
        ide_din = {16'h5678, 16'h1234};
        ide_req = {6'h2A, 6'h15};

        // status frame
        add(1, 16'h0063, 16'h0000, 0, 0, 5'h00, 2'd0);
        add(0, 16'h0000, 16'hE015, 0, 0, 5'h00, 2'd0);
        add(0, 16'h0000, 16'hE42A, 0, 0, 5'h00, 2'd0);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h00, 2'd0);
        // DMA write ch1, addr 0x10
        add(1, 16'h0061, 16'h0000, 0, 0, 5'h00, 2'd0);
        add(0, 16'hF110, 16'h0000, 0, 0, 5'h10, 2'd1);
        add(0, 16'h0002, 16'h0000, 0, 0, 5'h10, 2'd1);
        add(0, 16'hAAAA, 16'h0000, 1, 0, 5'h10, 2'd1);
        add(0, 16'hBBBB, 16'h0000, 1, 0, 5'h11, 2'd1);
        // DMA write ch1, header 0xF010 (addr 0x00)
        add(1, 16'h0061, 16'h0000, 0, 0, 5'h12, 2'd1);
        add(0, 16'hF010, 16'h0000, 0, 0, 5'h00, 2'd1);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h00, 2'd1);
        add(0, 16'h1111, 16'h0000, 1, 0, 5'h00, 2'd1);
        add(0, 16'h2222, 16'h0000, 1, 0, 5'h01, 2'd1);
        // DMA write to data port 0xF holds address
        add(1, 16'h0061, 16'h0000, 0, 0, 5'h02, 2'd1);
        add(0, 16'hF00F, 16'h0000, 0, 0, 5'h0F, 2'd0);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h0F, 2'd0);
        add(0, 16'hCCCC, 16'h0000, 1, 0, 5'h0F, 2'd0);
        add(0, 16'hDDDD, 16'h0000, 1, 0, 5'h0F, 2'd0);
        // DMA read with channel 3 (out of range): no pulses, zero responses
        add(1, 16'h0062, 16'h0000, 0, 0, 5'h0F, 2'd0);
        add(0, 16'hF030, 16'h0000, 0, 0, 5'h00, 2'd3);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h00, 2'd3);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h00, 2'd3);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h00, 2'd3);
        // DMA read ch0
        add(1, 16'h0062, 16'h0000, 0, 0, 5'h00, 2'd3);
        add(0, 16'hF000, 16'h0000, 0, 0, 5'h00, 2'd0);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h00, 2'd0);
        add(0, 16'h0000, 16'h0000, 0, 1, 5'h00, 2'd0);
        add(0, 16'h0000, 16'h1234, 0, 1, 5'h01, 2'd0);
        // DMA read ch1
        add(1, 16'h0062, 16'h0000, 0, 0, 5'h02, 2'd0);
        add(0, 16'hF110, 16'h0000, 0, 0, 5'h10, 2'd1);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h10, 2'd1);
        add(0, 16'h0000, 16'h0000, 0, 1, 5'h10, 2'd1);
        add(0, 16'h0000, 16'h5678, 0, 1, 5'h11, 2'd1);
        // unknown command: header and data ignored
        add(1, 16'h00FF, 16'h0000, 0, 0, 5'h12, 2'd1);
        add(0, 16'hF000, 16'h0000, 0, 0, 5'h12, 2'd1);
        add(0, 16'h0000, 16'h0000, 0, 0, 5'h12, 2'd1);
        add(0, 16'h5555, 16'h0000, 0, 0, 5'h12, 2'd1);

        repeat (2) @(negedge clk_sys);
        chk("rst_io_dout", 32'(io_dout), 32'h0);
        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_evt_ovf", 32'(evt_overflow), 32'h0);
        chk("rst_ide", {11'h0, ide_rd, ide_wr, ide_sel, ide_addr, 3'h0, mouse_buttons, 8'h0}, 32'h0);
        chk("rst_ide_dout", 32'(ide_dout), 32'h0);
        reset = 1'b0;

        io_fpga = 1'b1;
        #1 chk("fpga_mux", 32'(io_dout), 32'hBEEF);
        io_fpga = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].nf) frame_start();
            else @(negedge clk_sys);
            chk($sformatf("v%0d_io_dout", i), 32'(io_dout), 32'(tv[i].rd));
            word(tv[i].din, 1'b0);
            chk($sformatf("v%0d_ide_wr", i), 32'(ide_wr), 32'(tv[i].wr));
            chk($sformatf("v%0d_ide_rd", i), 32'(ide_rd), 32'(tv[i].rdp));
            chk($sformatf("v%0d_ide_addr", i), 32'(ide_addr), 32'(tv[i].addr));
            chk($sformatf("v%0d_ide_sel", i), 32'(ide_sel), 32'(tv[i].sel));
            chk($sformatf("v%0d_ide_dout", i), 32'(ide_dout), 32'(tv[i].din));
        end

        // buttons, one event, then reset mid DMA-write frame at wc==4
        frame_start();
        word(16'h0002, 1'b0);
        word(16'h000D, 1'b0);
        chk("buttons", 32'(mouse_buttons), 32'h5);
        evt_frame(16'h0005, 8'h42, 1'b0);
        chk("pre_rst_valid", 32'(evt_valid), 32'h1);
        frame_start();
        word(16'h0061, 1'b0);
        word(16'hF110, 1'b0);
        word(16'h0000, 1'b0);
        word(16'h1111, 1'b0);
        chk("pre_rst_wr", 32'(ide_wr), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_evt", {evt_valid, evt_overflow, evt_type, evt_data}, 32'h0);
        chk("mid_rst_ide", {11'h0, ide_rd, ide_wr, ide_sel, ide_addr, 3'h0, mouse_buttons, 8'h0}, 32'h0);
        chk("mid_rst_dout", {ide_dout, io_dout}, 32'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        chk("post_rst_valid", 32'(evt_valid), 32'h0);
        frame_start();
        word(16'h0063, 1'b0);
        chk("post_rst_status", 32'(io_dout), 32'hE015);

        // overflow: 9 keyboard events into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) evt_frame(16'h0005, 8'(i), 1'b0);
        chk("ovf_flag", 32'(evt_overflow), 32'h1);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("drain%0d", i), 2'd2, 8'(i));
        chk("drained_valid", 32'(evt_valid), 32'h0);
        chk("ovf_sticky", 32'(evt_overflow), 32'h1);
        evt_frame(16'h0003, 8'h11, 1'b0);
        chk("mx_valid", 32'(evt_valid), 32'h1);
        chk("mx_type", 32'(evt_type), 32'h0);
        frame_start();
        word(16'h0064, 1'b0);
        chk("flush_valid", 32'(evt_valid), 32'h0);
        chk("flush_ovf", 32'(evt_overflow), 32'h0);

        // full FIFO: push with a simultaneous pop
        for (int i = 0; i < 8; i++) evt_frame(16'h0005, 8'(8'h20 + i), 1'b0);
        chk("full_no_ovf", 32'(evt_overflow), 32'h0);
        evt_frame(16'h0004, 8'h55, 1'b1);
        chk("pushpop_ovf", 32'(evt_overflow), 32'h0);
        for (int i = 1; i < 8; i++) pop_check($sformatf("pp%0d", i), 2'd2, 8'(8'h20 + i));
        pop_check("pp_last", 2'd1, 8'h55);
        chk("pp_empty", 32'(evt_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
